scr1_pipe_lsu_mo: RTL and testbench
===================================

# scr1_pipe_lsu_mo

Multi-outstanding Load/Store Unit for the SCR1 pipeline, sitting between EXU and the DMEM port. Issues up to `OUTSTD` DMEM requests back-to-back without waiting for responses, tracks them in an in-order command FIFO, and returns load data and exceptions to EXU in issue order. Misalign checks are unchanged in kind. Byte-lane alignment of load and store data is optional.

## Interface
- `XLEN`, 32: data and address width; must equal `SCR1_DMEM_DWIDTH` and `SCR1_DMEM_AWIDTH`.
- `OUTSTD`, 2: maximum in-flight DMEM requests; legal range 1..4.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `exu2lsu_req_i`  in  1  EXU request, held until `lsu2exu_ack_o` or an exception.
- `exu2lsu_cmd_i`  in  `type_scr1_lsu_cmd_sel_e`  LSU command.
- `exu2lsu_addr_i`  in  XLEN  byte address.
- `exu2lsu_sdata_i`  in  XLEN  store data.
- `lsu2exu_ack_o`  out  1  request accepted by DMEM this cycle.
- `lsu2exu_rdy_o`  out  1  response or exception delivered this cycle.
- `lsu2exu_ldata_o`  out  XLEN  extended load data.
- `lsu2exu_exc_o`  out  1  exception this cycle.
- `lsu2exu_exc_code_o`  out  `SCR1_EXC_CODE_WIDTH_E`  exception code.
- `lsu2exu_busy_o`  out  1  at least one request in flight.
- `lsu_err_spurious_o`  out  1  sticky flag: a DMEM response arrived with no request in flight.
- `lsu2dmem_req_o`, `lsu2dmem_cmd_o`, `lsu2dmem_width_o`, `lsu2dmem_addr_o`, `lsu2dmem_wdata_o`  out: standard DMEM request bus.
- `dmem2lsu_req_ack_i`  in  1; `dmem2lsu_rdata_i`  in  XLEN; `dmem2lsu_resp_i`  in  `type_scr1_mem_resp_e`.

## Operation
- **Misalign.** `mslgn` is (H-width & addr[0]) | (W-width & |addr[1:0]). Loads give `SCR1_EXC_CODE_LD_ADDR_MISALIGN`; stores give `SCR1_EXC_CODE_ST_ADDR_MISALIGN`.
  - The exception is reported only when `cnt==0` and no response arrives that cycle; otherwise it is held off until then.
  - A misaligned request never reaches DMEM.
- **Issue.** `lsu2dmem_req_o = req & ~mslgn & (cnt < OUTSTD)`.
  - On `req_ack` the request is accepted: `ack_o=1`, and {cmd, addr[1:0]} is pushed into the FIFO.
  - `cmd_o` is WR for SB/SH/SW, otherwise RD. Width follows the command.
- **Response.** `resp_i` of RDY_OK or RDY_ER pops the FIFO head and drives `rdy_o=1`.
  - `ldata` is sign- or zero-extended per the head command: LB/LBU/LH/LHU/LW.
  - RDY_ER drives `exc_o=1`, with `LD_ACCESS_FAULT` or `ST_ACCESS_FAULT` per the head command.
  - Later in-flight responses are still delivered normally.
- **Priority.** A response has priority over a misalign report in the same cycle.
- **Counter and pointers.**
  - `cnt`, 0..OUTSTD: push and pop in the same cycle leaves it unchanged.
  - Read and write pointers wrap modulo OUTSTD.
  - At `cnt==OUTSTD`, no issue is possible that cycle, even if a pop coincides.
- **Spurious response.** A response with `cnt==0` is ignored: no `rdy_o`, no pop. It sets `lsu_err_spurious_o`, which clears only on reset.
- **Reset.** Asserting `rst` at any time clears `cnt`, the pointers, the FIFO and the sticky flag immediately, abandoning in-flight requests.
  - While `rst=1`: `req_o=0`, `ack_o=0`, `rdy_o=0`, `exc_o=0`, `busy_o=0`, `lsu_err_spurious_o=0`, `exc_code_o=INSTR_MISALIGN`, `ldata=0`.

## Timing
- Issue is combinational: `req_o` and `ack_o` appear in the same cycle as `req_i` and `req_ack_i`.
- Back-to-back issue: 1 request per cycle up to `OUTSTD`.
- Load data and response exceptions are combinational from `rdata_i`/`resp_i` in the response cycle, so minimum latency is 1 cycle after acceptance.
- `busy_o` is registered and reflects `cnt != 0`.
- A misalign exception is one cycle, level-based: it persists while `req_i` is held.

## Configuration
- `SCR1_LSU_LANE_ALIGN_EN` defined: lane alignment is on.
  - Load data is shifted right by 8*addr[1:0] (stored in the FIFO) before extension.
  - Store data is replicated: SB gives {4{sdata[7:0]}}, SH gives {2{sdata[15:0]}}, SW is unchanged.
- Undefined: data passes raw in both directions, the FIFO stores no address bits, and extension uses the low bits.

## Test plan
- **Back-to-back issue.** OUTSTD=2, ack always 1; issue LW 0x100, LW 0x104, LW 0x108 on consecutive cycles -> two acks, third `req_o=0` until the first RDY_OK. Responses 0xA, 0xB return in order.
- **Sign extension.** LB to 0x203 with rdata 0x80000000, lane-align on -> `ldata=0xFFFFFF80`. Lane-align off, rdata 0x00000080 -> `0xFFFFFF80`.
- **Misalign held off.** With one LW in flight, a misaligned SH to 0x301 -> no exc until the pending response. The next cycle gives `exc_o=1`, code ST_ADDR_MISALIGN, `req_o` never high.
- **Access fault.** RDY_ER on an outstanding SW -> `exc_o=1`, code ST_ACCESS_FAULT. The following in-flight LW still returns its RDY_OK data.
- **Spurious response and reset.** RDY_OK with `cnt==0` -> `rdy_o=0`, `lsu_err_spurious_o=1`, sticky. Asserting `rst` with 2 in flight clears it and gives `busy_o=0` the same cycle.

Source files
------------

// File: rtl/scr1_pipe_lsu_mo.sv
// scr1_pipe_lsu_mo: multi-outstanding LSU between EXU and the DMEM port.
// Optional byte-lane alignment is enabled by SCR1_LSU_LANE_ALIGN_EN.
module scr1_pipe_lsu_mo #(
  parameter int XLEN   = 32,
  parameter int OUTSTD = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu2lsu_req_i,
  input  logic [3:0]      exu2lsu_cmd_i,
  input  logic [XLEN-1:0] exu2lsu_addr_i,
  input  logic [XLEN-1:0] exu2lsu_sdata_i,
  output logic            lsu2exu_ack_o,
  output logic            lsu2exu_rdy_o,
  output logic [XLEN-1:0] lsu2exu_ldata_o,
  output logic            lsu2exu_exc_o,
  output logic [3:0]      lsu2exu_exc_code_o,
  output logic            lsu2exu_busy_o,
  output logic            lsu_err_spurious_o,
  output logic            lsu2dmem_req_o,
  output logic            lsu2dmem_cmd_o,
  output logic [1:0]      lsu2dmem_width_o,
  output logic [XLEN-1:0] lsu2dmem_addr_o,
  output logic [XLEN-1:0] lsu2dmem_wdata_o,
  input  logic            dmem2lsu_req_ack_i,
  input  logic [XLEN-1:0] dmem2lsu_rdata_i,
  input  logic [1:0]      dmem2lsu_resp_i
);

  localparam logic [3:0] CMD_LB  = 4'd1;
  localparam logic [3:0] CMD_LH  = 4'd2;
  localparam logic [3:0] CMD_LW  = 4'd3;
  localparam logic [3:0] CMD_LBU = 4'd4;
  localparam logic [3:0] CMD_LHU = 4'd5;
  localparam logic [3:0] CMD_SB  = 4'd6;
  localparam logic [3:0] CMD_SH  = 4'd7;
  localparam logic [3:0] CMD_SW  = 4'd8;

  localparam logic       MEM_RD = 1'b0;
  localparam logic       MEM_WR = 1'b1;
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  localparam logic [1:0] RESP_OK = 2'd1;
  localparam logic [1:0] RESP_ER = 2'd2;

  localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_LD_MISALIGN    = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT       = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN    = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT       = 4'd7;

  localparam int PW    = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
  localparam int DEPTH = 1 << PW;
  localparam logic [2:0]    MAX_CNT  = 3'(OUTSTD);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTD - 1);

  logic [2:0]    cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [3:0]    fifo_cmd_q [DEPTH];
  logic [3:0]    fifo_cmd_d [DEPTH];
  logic          busy_q, busy_d;
  logic          spur_q, spur_d;

`ifdef SCR1_LSU_LANE_ALIGN_EN
  logic [1:0]    fifo_ofs_q [DEPTH];
  logic [1:0]    fifo_ofs_d [DEPTH];
`endif

  logic          is_st;
  logic          sz_b;
  logic          sz_h;
  logic          mslgn;
  logic          resp_vld;
  logic          resp_er;
  logic          cnt_zero;
  logic          can_issue;
  logic          dmem_req;
  logic          push;
  logic          pop;
  logic          mslgn_exc;
  logic [3:0]    head_cmd;
  logic          head_st;
  logic [XLEN-1:0] ld_raw;
  logic [XLEN-1:0] ldata;
  logic [3:0]    exc_code;

  // Decode command kind and access width for the current EXU request
  always_comb begin
    is_st = 1'b0;
    sz_b  = 1'b0;
    sz_h  = 1'b0;
    case (exu2lsu_cmd_i)
      CMD_LB, CMD_LBU: sz_b = 1'b1;
      CMD_LH, CMD_LHU: sz_h = 1'b1;
      CMD_SB: begin
        is_st = 1'b1;
        sz_b  = 1'b1;
      end
      CMD_SH: begin
        is_st = 1'b1;
        sz_h  = 1'b1;
      end
      CMD_SW:  is_st = 1'b1;
      default: ;
    endcase
  end

  // Anything that is not byte or half is a word access
  assign mslgn = (sz_h & exu2lsu_addr_i[0])
               | (~sz_b & ~sz_h & (|exu2lsu_addr_i[1:0]));

  assign resp_vld  = (dmem2lsu_resp_i == RESP_OK)
                   | (dmem2lsu_resp_i == RESP_ER);
  assign resp_er   = (dmem2lsu_resp_i == RESP_ER);
  assign cnt_zero  = (cnt_q == 3'd0);
  assign can_issue = (cnt_q < MAX_CNT);

  // A full FIFO blocks issue even if a pop lands in the same cycle
  assign dmem_req  = exu2lsu_req_i & ~mslgn & can_issue & ~rst;
  assign push      = dmem_req & dmem2lsu_req_ack_i;
  assign pop       = resp_vld & ~cnt_zero & ~rst;

  // Misalign is reported only once the pipe has drained and is quiet
  assign mslgn_exc = exu2lsu_req_i & mslgn & cnt_zero
                   & ~resp_vld & ~rst;

  assign head_cmd = fifo_cmd_q[rptr_q];
  assign head_st  = (head_cmd == CMD_SB)
                  | (head_cmd == CMD_SH)
                  | (head_cmd == CMD_SW);

`ifdef SCR1_LSU_LANE_ALIGN_EN
  assign ld_raw = dmem2lsu_rdata_i >> {fifo_ofs_q[rptr_q], 3'b000};
`else
  assign ld_raw = dmem2lsu_rdata_i;
`endif

  // Extend the head-of-FIFO load data; stores return zero
  always_comb begin
    ldata = '0;
    if (pop) begin
      case (head_cmd)
        CMD_LB:  ldata = {{(XLEN-8){ld_raw[7]}}, ld_raw[7:0]};
        CMD_LBU: ldata = {{(XLEN-8){1'b0}}, ld_raw[7:0]};
        CMD_LH:  ldata = {{(XLEN-16){ld_raw[15]}}, ld_raw[15:0]};
        CMD_LHU: ldata = {{(XLEN-16){1'b0}}, ld_raw[15:0]};
        CMD_LW:  ldata = ld_raw;
        default: ldata = '0;
      endcase
    end
  end

  // Response errors outrank misalign; idle code is INSTR_MISALIGN
  always_comb begin
    exc_code = EXC_INSTR_MISALIGN;
    unique case (1'b1)
      pop & resp_er:
        exc_code = head_st ? EXC_ST_FAULT : EXC_LD_FAULT;
      mslgn_exc:
        exc_code = is_st ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
      default: ;
    endcase
  end

  // Store data: replicate narrow stores across lanes when aligning
  always_comb begin
    lsu2dmem_wdata_o = exu2lsu_sdata_i;
`ifdef SCR1_LSU_LANE_ALIGN_EN
    case (exu2lsu_cmd_i)
      CMD_SB:  lsu2dmem_wdata_o = {(XLEN/8){exu2lsu_sdata_i[7:0]}};
      CMD_SH:  lsu2dmem_wdata_o = {(XLEN/16){exu2lsu_sdata_i[15:0]}};
      default: lsu2dmem_wdata_o = exu2lsu_sdata_i;
    endcase
`endif
  end

  // Next-state for counter, pointers, FIFO and sticky flag
  always_comb begin
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fifo_cmd_d = fifo_cmd_q;
`ifdef SCR1_LSU_LANE_ALIGN_EN
    fifo_ofs_d = fifo_ofs_q;
`endif
    spur_d     = spur_q | (resp_vld & cnt_zero);
    if (push) begin
      fifo_cmd_d[wptr_q] = exu2lsu_cmd_i;
`ifdef SCR1_LSU_LANE_ALIGN_EN
      fifo_ofs_d[wptr_q] = exu2lsu_addr_i[1:0];
`endif
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
    busy_d = (cnt_d != 3'd0);
  end

  // State registers; reset abandons all in-flight requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      busy_q <= 1'b0;
      spur_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_cmd_q[i] <= '0;
`ifdef SCR1_LSU_LANE_ALIGN_EN
        fifo_ofs_q[i] <= '0;
`endif
      end
    end else begin
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      busy_q     <= busy_d;
      spur_q     <= spur_d;
      fifo_cmd_q <= fifo_cmd_d;
`ifdef SCR1_LSU_LANE_ALIGN_EN
      fifo_ofs_q <= fifo_ofs_d;
`endif
    end
  end

  assign lsu2dmem_req_o     = dmem_req;
  assign lsu2dmem_cmd_o     = is_st ? MEM_WR : MEM_RD;
  assign lsu2dmem_width_o   = sz_b ? W_BYTE : (sz_h ? W_HALF : W_WORD);
  assign lsu2dmem_addr_o    = exu2lsu_addr_i;

  assign lsu2exu_ack_o      = push;
  assign lsu2exu_rdy_o      = pop;
  assign lsu2exu_ldata_o    = ldata;
  assign lsu2exu_exc_o      = (pop & resp_er) | mslgn_exc;
  assign lsu2exu_exc_code_o = exc_code;
  assign lsu2exu_busy_o     = busy_q;
  assign lsu_err_spurious_o = spur_q;

endmodule

// File: tb/tb_scr1_pipe_lsu_mo.sv
// tb_scr1_pipe_lsu_mo: directed and random checks of the LSU
// against a queue-based transaction model.
module tb_scr1_pipe_lsu_mo;

  localparam int OUTSTD = 2;

`ifdef SCR1_LSU_LANE_ALIGN_EN
  localparam bit LANE = 1'b1;
`else
  localparam bit LANE = 1'b0;
`endif

  localparam logic [3:0] C_NONE = 4'd0;
  localparam logic [3:0] C_LB   = 4'd1;
  localparam logic [3:0] C_LH   = 4'd2;
  localparam logic [3:0] C_LW   = 4'd3;
  localparam logic [3:0] C_LBU  = 4'd4;
  localparam logic [3:0] C_LHU  = 4'd5;
  localparam logic [3:0] C_SB   = 4'd6;
  localparam logic [3:0] C_SH   = 4'd7;
  localparam logic [3:0] C_SW   = 4'd8;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_OK   = 2'd1;
  localparam logic [1:0] R_ER   = 2'd2;

  typedef struct packed {
    logic [3:0] cmd;
    logic [1:0] ofs;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [3:0]  cmd = C_NONE;
  logic [31:0] addr = '0;
  logic [31:0] sdata = '0;
  logic        dack = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  resp = R_IDLE;

  logic        ack_o;
  logic        rdy_o;
  logic [31:0] ldata_o;
  logic        exc_o;
  logic [3:0]  code_o;
  logic        busy_o;
  logic        spur_o;
  logic        dreq_o;
  logic        dcmd_o;
  logic [1:0]  dwidth_o;
  logic [31:0] daddr_o;
  logic [31:0] dwdata_o;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  bit   spur_m = 1'b0;
  bit   m_push;
  bit   m_pop;
  bit   m_spur;
  ent_t m_new;

  scr1_pipe_lsu_mo #(.XLEN(32), .OUTSTD(OUTSTD)) dut (
    .clk                (clk),
    .rst                (rst),
    .exu2lsu_req_i      (req),
    .exu2lsu_cmd_i      (cmd),
    .exu2lsu_addr_i     (addr),
    .exu2lsu_sdata_i    (sdata),
    .lsu2exu_ack_o      (ack_o),
    .lsu2exu_rdy_o      (rdy_o),
    .lsu2exu_ldata_o    (ldata_o),
    .lsu2exu_exc_o      (exc_o),
    .lsu2exu_exc_code_o (code_o),
    .lsu2exu_busy_o     (busy_o),
    .lsu_err_spurious_o (spur_o),
    .lsu2dmem_req_o     (dreq_o),
    .lsu2dmem_cmd_o     (dcmd_o),
    .lsu2dmem_width_o   (dwidth_o),
    .lsu2dmem_addr_o    (daddr_o),
    .lsu2dmem_wdata_o   (dwdata_o),
    .dmem2lsu_req_ack_i (dack),
    .dmem2lsu_rdata_i   (rdata),
    .dmem2lsu_resp_i    (resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_store(input logic [3:0] c);
    return (c == C_SB) || (c == C_SH) || (c == C_SW);
  endfunction

  function automatic int nbytes(input logic [3:0] c);
    if (c == C_LB || c == C_LBU || c == C_SB) return 1;
    if (c == C_LH || c == C_LHU || c == C_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] c,
                                           input logic [1:0] ofs,
                                           input logic [31:0] rd);
    longint unsigned d;
    int bits;
    bit sgn;
    d = rd;
    if (LANE) d = d / (64'd1 << (8 * int'(ofs)));
    case (c)
      C_LB:    begin bits = 8;  sgn = 1'b1; end
      C_LBU:   begin bits = 8;  sgn = 1'b0; end
      C_LH:    begin bits = 16; sgn = 1'b1; end
      C_LHU:   begin bits = 16; sgn = 1'b0; end
      C_LW:    begin bits = 32; sgn = 1'b0; end
      default: return 32'h0;
    endcase
    d = d % (64'd1 << bits);
    if (sgn && d >= (64'd1 << (bits - 1)))
      d = d + 64'h1_0000_0000 - (64'd1 << bits);
    return d[31:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] c,
                                            input logic [31:0] sd);
    if (LANE && c == C_SB) return (sd % 256) * 32'h0101_0101;
    if (LANE && c == C_SH) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  task automatic drive(input bit r, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] sd,
                       input bit k, input logic [1:0] rs,
                       input logic [31:0] rd);
    @(negedge clk);
    req = r; cmd = c; addr = a; sdata = sd;
    dack = k; resp = rs; rdata = rd;
    #1;
  endtask

  task automatic check_model();
    bit mis, rv, ereq, mexc, eexc;
    logic [31:0] eld;
    logic [3:0] ecode;
    int n;
    n = nbytes(cmd);
    mis  = (addr % n) != 0;
    rv   = (resp == R_OK) || (resp == R_ER);
    ereq = req && !mis && (q.size() < OUTSTD);
    m_push = ereq && dack;
    m_pop  = rv && (q.size() > 0);
    m_spur = rv && (q.size() == 0);
    m_new  = '{cmd: cmd, ofs: addr[1:0]};
    mexc = req && mis && (q.size() == 0) && !rv;
    eld = 32'h0; eexc = 1'b0; ecode = 4'd0;
    if (m_pop) begin
      eld = exp_load(q[0].cmd, q[0].ofs, rdata);
      if (resp == R_ER) begin
        eexc = 1'b1;
        ecode = is_store(q[0].cmd) ? 4'd7 : 4'd5;
      end
    end else if (mexc) begin
      eexc = 1'b1;
      ecode = is_store(cmd) ? 4'd6 : 4'd4;
    end
    chk("req_o", 32'(dreq_o), 32'(ereq));
    chk("ack_o", 32'(ack_o), 32'(m_push));
    chk("rdy_o", 32'(rdy_o), 32'(m_pop));
    chk("ldata", ldata_o, eld);
    chk("exc_o", 32'(exc_o), 32'(eexc));
    chk("exc_code", 32'(code_o), 32'(ecode));
    chk("busy_o", 32'(busy_o), 32'(q.size() != 0));
    chk("spurious", 32'(spur_o), 32'(spur_m));
    if (ereq) begin
      chk("dmem_cmd", 32'(dcmd_o), 32'(is_store(cmd)));
      chk("dmem_width", 32'(dwidth_o), (n == 1) ? 0 : (n == 2) ? 1 : 2);
      chk("dmem_addr", daddr_o, addr);
      if (is_store(cmd)) chk("dmem_wdata", dwdata_o, exp_wdata(cmd, sdata));
    end
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    if (m_pop) void'(q.pop_front());
    if (m_push) q.push_back(m_new);
    if (m_spur) spur_m = 1'b1;
  endtask

  task automatic cyc(input bit r, input logic [3:0] c,
                     input logic [31:0] a, input logic [31:0] sd,
                     input bit k, input logic [1:0] rs,
                     input logic [31:0] rd);
    drive(r, c, a, sd, k, rs, rd);
    check_model();
  endtask

  task automatic step(input bit r, input logic [3:0] c,
                      input logic [31:0] a, input logic [31:0] sd,
                      input bit k, input logic [1:0] rs,
                      input logic [31:0] rd);
    cyc(r, c, a, sd, k, rs, rd);
    commit();
  endtask

  task automatic idle();
    step(1'b0, C_NONE, 32'h0, 32'h0, 1'b0, R_IDLE, 32'h0);
  endtask

  initial begin
    int r;
    // Reset state with a live request and response on the inputs
    req = 1'b1; cmd = C_LW; addr = 32'h40; dack = 1'b1;
    resp = R_OK; rdata = 32'hDEAD_BEEF;
    #2;
    chk("rst_req_o", 32'(dreq_o), 0);
    chk("rst_ack_o", 32'(ack_o), 0);
    chk("rst_rdy_o", 32'(rdy_o), 0);
    chk("rst_exc_o", 32'(exc_o), 0);
    chk("rst_code", 32'(code_o), 0);
    chk("rst_ldata", ldata_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_spur", 32'(spur_o), 0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0; resp = R_IDLE; dack = 1'b0;
    idle();

    // Back-to-back issue up to the outstanding limit
    step(1'b1, C_LW, 32'h100, 0, 1'b1, R_IDLE, 0);
    cyc(1'b1, C_LW, 32'h104, 0, 1'b1, R_IDLE, 0);
    chk("b2b_ack2", 32'(ack_o), 1);
    commit();
    cyc(1'b1, C_LW, 32'h108, 0, 1'b1, R_IDLE, 0);
    chk("b2b_full_req", 32'(dreq_o), 0);
    commit();
    cyc(1'b1, C_LW, 32'h108, 0, 1'b1, R_OK, 32'hA);
    chk("b2b_resp_a", ldata_o, 32'hA);
    chk("b2b_full_pop_req", 32'(dreq_o), 0);
    commit();
    cyc(1'b1, C_LW, 32'h108, 0, 1'b1, R_OK, 32'hB);
    chk("b2b_resp_b", ldata_o, 32'hB);
    chk("b2b_req3", 32'(dreq_o), 1);
    commit();
    step(1'b0, C_NONE, 0, 0, 1'b0, R_OK, 32'hC);

    // Sign extension of a byte load at offset 3
    step(1'b1, C_LB, 32'h203, 0, 1'b1, R_IDLE, 0);
    cyc(1'b0, C_NONE, 0, 0, 1'b0, R_OK,
        LANE ? 32'h8000_0000 : 32'h0000_0080);
    chk("sext_lb", ldata_o, 32'hFFFF_FF80);
    commit();

    // Misaligned store held off behind a pending load
    step(1'b1, C_LW, 32'h400, 0, 1'b1, R_IDLE, 0);
    cyc(1'b1, C_SH, 32'h301, 32'h1234, 1'b1, R_IDLE, 0);
    chk("mis_hold_exc", 32'(exc_o), 0);
    commit();
    cyc(1'b1, C_SH, 32'h301, 32'h1234, 1'b1, R_OK, 32'h55);
    chk("mis_resp_rdy", 32'(rdy_o), 1);
    chk("mis_resp_exc", 32'(exc_o), 0);
    commit();
    cyc(1'b1, C_SH, 32'h301, 32'h1234, 1'b1, R_IDLE, 0);
    chk("mis_exc", 32'(exc_o), 1);
    chk("mis_code", 32'(code_o), 6);
    chk("mis_no_req", 32'(dreq_o), 0);
    commit();
    idle();

    // Access fault on a store followed by a good load
    step(1'b1, C_SW, 32'h500, 32'hCAFE_F00D, 1'b1, R_IDLE, 0);
    step(1'b1, C_LW, 32'h504, 0, 1'b1, R_IDLE, 0);
    cyc(1'b0, C_NONE, 0, 0, 1'b0, R_ER, 32'h0);
    chk("fault_exc", 32'(exc_o), 1);
    chk("fault_code", 32'(code_o), 7);
    commit();
    cyc(1'b0, C_NONE, 0, 0, 1'b0, R_OK, 32'h1234_5678);
    chk("fault_next_data", ldata_o, 32'h1234_5678);
    chk("fault_next_exc", 32'(exc_o), 0);
    commit();

    // Spurious response sets a sticky flag
    cyc(1'b0, C_NONE, 0, 0, 1'b0, R_OK, 32'h77);
    chk("spur_no_rdy", 32'(rdy_o), 0);
    commit();
    idle();
    idle();
    chk("spur_sticky", 32'(spur_o), 1);

    // Asynchronous reset with two requests in flight
    step(1'b1, C_LW, 32'h600, 0, 1'b1, R_IDLE, 0);
    step(1'b1, C_LHU, 32'h606, 0, 1'b1, R_IDLE, 0);
    chk("pre_rst_busy", 32'(busy_o), 1);
    @(negedge clk);
    req = 1'b1; cmd = C_LW; addr = 32'h700; dack = 1'b1; resp = R_IDLE;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_spur", 32'(spur_o), 0);
    chk("arst_req_o", 32'(dreq_o), 0);
    chk("arst_ack_o", 32'(ack_o), 0);
    q.delete();
    spur_m = 1'b0;
    @(negedge clk);
    rst = 1'b0; req = 1'b0; dack = 1'b0;
    idle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      step($urandom_range(0, 3) != 0,
           4'($urandom_range(1, 8)),
           $urandom, $urandom,
           $urandom_range(0, 1) == 1,
           (r < 5) ? R_IDLE : (r < 8) ? R_OK : R_ER,
           $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
